// File: rtl/multi_cycle_add_sub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, carry registered between slices.
// Optional macro MULTI_CYCLE_ADD_SUB_B2B_EN enables DONE->BUSY back-to-back operand acceptance.
module multi_cycle_add_sub #(
  parameter int BIT_NUM = 64,
  parameter int CHUNK   = 16
) (
  input  logic               clk_i,
  input  logic               arst_ni,
  input  logic [BIT_NUM-1:0] op1_i,
  input  logic [BIT_NUM-1:0] op2_i,
  input  logic               sgn_op2_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [BIT_NUM-1:0] sum_o,
  output logic               carry_o,
  output logic               overflow_o,
  output logic               out_valid_o,
  input  logic               out_ready_i
);

  localparam int NUM_CHUNKS = BIT_NUM / CHUNK;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  generate
    if (BIT_NUM % CHUNK != 0) begin : g_bad_chunk
      $error("multi_cycle_add_sub: BIT_NUM must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [BIT_NUM-1:0] r_op1;
  logic [BIT_NUM-1:0] r_op2;
  logic [BIT_NUM-1:0] r_sum;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic               r_carry_out;
  logic               r_overflow;

  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic [CHUNK-1:0] w_a;
  logic [CHUNK-1:0] w_b;
  logic [CHUNK-1:0] w_s;
  logic             w_c;
  logic             w_msb_cin;

  assign w_a    = r_op1[r_idx*CHUNK +: CHUNK];
  assign w_b    = r_op2[r_idx*CHUNK +: CHUNK];
  assign {w_c, w_s} = {1'b0, w_a} + {1'b0, w_b} + {{CHUNK{1'b0}}, r_carry};
  // Carry into the top bit recovered from the top bit's own sum: s = a ^ b ^ cin.
  assign w_msb_cin = w_s[CHUNK-1] ^ w_a[CHUNK-1] ^ w_b[CHUNK-1];
  assign w_last    = (r_idx == LAST_IDX);

  assign sum_o      = r_sum;
  assign carry_o    = r_carry_out;
  assign overflow_o = r_overflow;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    in_ready_o   = 1'b0;
    out_valid_o  = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          w_load       = 1'b1;
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
`ifdef MULTI_CYCLE_ADD_SUB_B2B_EN
        in_ready_o = out_ready_i;
        if (out_ready_i) begin
          if (in_valid_i) begin
            w_load       = 1'b1;
            w_state_next = BUSY;
          end else begin
            w_state_next = IDLE;
          end
        end
`else
        if (out_ready_i) begin
          w_state_next = IDLE;
        end
`endif
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_op1       <= '0;
      r_op2       <= '0;
      r_sum       <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_load) begin
      r_op1   <= op1_i;
      r_op2   <= op2_i ^ {BIT_NUM{sgn_op2_i}};
      r_carry <= sgn_op2_i;
      r_idx   <= '0;
    end else if (w_step) begin
      r_sum[r_idx*CHUNK +: CHUNK] <= w_s;
      r_carry <= w_c;
      if (w_last) begin
        r_idx       <= '0;
        r_carry_out <= w_c;
        r_overflow  <= w_msb_cin ^ w_c;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

endmodule
